// File: rtl/psum_collector_pkg.sv
// rtl/psum_collector_pkg.sv - shared types, sizes and helpers for the psum collector
package psum_collector_pkg;

  localparam int PSUM_W        = 16;
  localparam int ADDR_W        = 8;
  localparam int L1_OFMAP_SIZE = 16;
  localparam int L2_OFMAP_SIZE = 8;
  localparam int L3_OFMAP_SIZE = 4;

  typedef enum logic [1:0] {MODE1, MODE2, MODE3, MODE4} OP_MODE;
  typedef enum logic [1:0] {STG_IDLE, STG_LOAD, CONV, STG_STORE} OP_STAGE;
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} collect_state_t;

  typedef struct packed {
    logic              valid;
    logic [PSUM_W-1:0] psum;
    logic [1:0]        filter_idx;
  } PSUM_PACKET;

  // Last psum index of a pass; each index carries four filter results.
  function automatic logic [5:0] psum_idx_max(input OP_MODE mode);
    case (mode)
      MODE1, MODE2: return 6'(L1_OFMAP_SIZE - 1);
      MODE3:        return 6'(L2_OFMAP_SIZE - 1);
      default:      return 6'(L3_OFMAP_SIZE - 1);
    endcase
  endfunction

endpackage

// File: rtl/psum_fifo.sv
// rtl/psum_fifo.sv - staging FIFO between psum accept and ofmap write
module psum_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             last,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign last      = (count == CNT_ONE);
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/psum_collector.sv
// rtl/psum_collector.sv - collects last-row psums, applies ReLU and streams them to the ofmap buffer
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  PSUM_PACKET        psum_in,
  output logic              psum_ack,
  input  OP_MODE            mode_in,
  input  logic              change_mode,
  input  logic              conv_continue,
  input  OP_STAGE           op_stage_in,
  input  logic              relu_en,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PSUM_W-1:0] wr_data,
  output logic              layer_done,
  output logic              seq_err
);

  localparam int ENTRY_W = ADDR_W + PSUM_W;

  collect_state_t     state;
  collect_state_t     state_nx;
  OP_MODE             cur_mode;
  logic [1:0]         exp_filter;
  logic [5:0]         exp_psum;
  logic               clear;
  logic               pop;
  logic               final_accept;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_last;
  logic [PSUM_W-1:0]  relu_psum;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  // A clear outranks every other event, so it also suppresses accept and pop.
  assign clear        = change_mode | conv_continue;
  assign pop          = wr_valid & wr_ready & ~clear;
  assign final_accept = psum_ack && (exp_filter == 2'd3) && (exp_psum == psum_idx_max(cur_mode));
  assign relu_psum    = (relu_en && psum_in.psum[PSUM_W-1]) ? '0 : psum_in.psum;
  assign push_entry   = {exp_psum, exp_filter, relu_psum};
  assign wr_valid     = ~fifo_empty;
  assign {wr_addr, wr_data} = head_entry;

  psum_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (clear),
    .push      (psum_ack),
    .push_data (push_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .last      (fifo_last),
    .head_data (head_entry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // DRAIN completes on the cycle the final entry leaves, so DONE follows the last write directly.
  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (op_stage_in == CONV) state_nx = COLLECT;
        COLLECT: if (final_accept) state_nx = DRAIN;
        DRAIN:   if (fifo_empty || (fifo_last && pop)) state_nx = DONE;
        DONE:    state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    psum_ack   = rst_n & ~clear & psum_in.valid & (state == COLLECT)
               & (op_stage_in == CONV) & ~fifo_full;
    layer_done = (state == DONE);
  end

  // Addresses come from the expected counters; a wrong incoming filter_idx only raises seq_err.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_mode   <= MODE1;
      exp_filter <= '0;
      exp_psum   <= '0;
      seq_err    <= 1'b0;
    end else begin
      if (change_mode) cur_mode <= mode_in;
      if (clear) begin
        exp_filter <= '0;
        exp_psum   <= '0;
        seq_err    <= 1'b0;
      end else if (psum_ack) begin
        exp_filter <= exp_filter + 2'd1;
        if (exp_filter == 2'd3) exp_psum <= exp_psum + 6'd1;
        if (psum_in.filter_idx != exp_filter) seq_err <= 1'b1;
      end
    end
  end

endmodule
